pixel_packer_24to32: RTL and testbench



---
 rtl/pixel_stream_pkg.sv | 19 +
 rtl/pixel_packer_24to32_if.sv | 29 ++
 rtl/stream_out_reg.sv | 46 ++++
 rtl/pixel_packer_24to32.sv | 126 ++++++++++++
 tb/tb_pixel_packer_24to32.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the 24-bit pixel to 32-bit video stream path.
package pixel_stream_pkg;

    localparam int PIXEL_W = 24;
    localparam int WORD_W  = 32;
    localparam int KEEP_W  = WORD_W / 8;

    localparam logic [KEEP_W-1:0] TKEEP_ALL = 4'hF;

    localparam int X_PIXELS_DEF = 640;
    localparam int Y_PIXELS_DEF = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/pixel_packer_24to32_if.sv
// Pixel input handshake and 32-bit video stream output bundled together.
interface pixel_packer_24to32_if;
    import pixel_stream_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [PIXEL_W-1:0]  in_pixel;

    logic [WORD_W-1:0]   out_stream_tdata;
    logic [KEEP_W-1:0]   out_stream_tkeep;
    logic                out_stream_tvalid;
    logic                out_stream_tready;
    logic                out_stream_tuser;
    logic                out_stream_tlast;

    // Pixel source and stream sink side (testbench / surrounding system).
    modport master (
        output in_valid, in_pixel, out_stream_tready,
        input  in_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tvalid, out_stream_tuser, out_stream_tlast
    );

    // Packer side.
    modport slave (
        input  in_valid, in_pixel, out_stream_tready,
        output in_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tvalid, out_stream_tuser, out_stream_tlast
    );
endinterface

// File: rtl/stream_out_reg.sv
// Single-entry output register with valid/ready carrying data, tuser and tlast.
module stream_out_reg
    import pixel_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_user,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    output logic              o_user,
    output logic              o_last
);

    logic              r_valid;
    logic [WORD_W-1:0] r_data;
    logic              r_user;
    logic              r_last;

    // Load replaces the held word (even when it is handshaken the same cycle);
    // otherwise a handshake empties the register and the payload is left as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_user  <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_user  <= i_user;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_user  = r_user;
    assign o_last  = r_last;

endmodule

// File: rtl/pixel_packer_24to32.sv
// Packs 24-bit RGB pixels into 32-bit video stream words (4 pixels -> 3 words)
// and tags each word with start-of-frame (tuser) and end-of-line (tlast).
module pixel_packer_24to32
    import pixel_stream_pkg::*;
#(
    parameter int X_PIXELS = X_PIXELS_DEF,
    parameter int Y_PIXELS = Y_PIXELS_DEF
)(
    input logic                  out_stream_aclk,
    input logic                  periph_reset,
    pixel_packer_24to32_if.slave bus
);

    localparam int X_WORDS = X_PIXELS * 3 / 4;
    localparam int XCW     = $clog2(X_WORDS + 1);
    localparam int YCW     = $clog2(Y_PIXELS + 1);

    logic [1:0]         r_phase;
    logic [PIXEL_W-1:0] r_residue;
    logic [XCW-1:0]     r_x_word;
    logic [YCW-1:0]     r_y_line;

    pixel_t             w_pix;
    logic               w_out_valid;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_load;
    logic               w_out_hs;
    logic [WORD_W-1:0]  w_word;
    logic [PIXEL_W-1:0] w_residue_nx;
    logic [XCW-1:0]     w_x_inc;
    logic [YCW-1:0]     w_y_inc;
    logic [XCW-1:0]     w_idx_x;
    logic [YCW-1:0]     w_idx_y;
    logic               w_user;
    logic               w_last;

    assign w_pix      = pixel_t'(bus.in_pixel);
    // Phase 0 never loads a word, so one pixel may always be absorbed into residue.
    assign w_in_ready = (r_phase == 2'd0) || !w_out_valid || bus.out_stream_tready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_load     = w_accept && (r_phase != 2'd0);
    assign w_out_hs   = w_out_valid && bus.out_stream_tready;

    // Counter values one word beyond the current position, with line/frame wrap.
    always_comb begin
        w_x_inc = r_x_word + XCW'(1);
        w_y_inc = r_y_line;
        if (r_x_word == XCW'(X_WORDS - 1)) begin
            w_x_inc = '0;
            w_y_inc = (r_y_line == YCW'(Y_PIXELS - 1)) ? '0 : r_y_line + YCW'(1);
        end
    end

    // The counters point at the word currently held (or next to be loaded if empty);
    // a load alongside a pending word can only happen as that word leaves, so the
    // new word's index is one beyond it.
    always_comb begin
        w_idx_x = w_out_valid ? w_x_inc : r_x_word;
        w_idx_y = w_out_valid ? w_y_inc : r_y_line;
        w_user  = (w_idx_x == '0) && (w_idx_y == '0);
        w_last  = (w_idx_x == XCW'(X_WORDS - 1));
    end

    // Word assembly from residue plus the incoming pixel, and the leftover bits.
    always_comb begin
        w_word       = '0;
        w_residue_nx = r_residue;
        case (r_phase)
            2'd0: w_residue_nx = w_pix;
            2'd1: begin
                w_word       = {w_pix.b, r_residue};
                w_residue_nx = {8'h00, w_pix.r, w_pix.g};
            end
            2'd2: begin
                w_word       = {w_pix.g, w_pix.b, r_residue[15:0]};
                w_residue_nx = {16'h0000, w_pix.r};
            end
            default: begin
                w_word       = {w_pix, r_residue[7:0]};
                w_residue_nx = '0;
            end
        endcase
    end

    // Pixel phase and residue advance on every accepted pixel.
    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            r_phase   <= 2'd0;
            r_residue <= '0;
        end else if (w_accept) begin
            r_phase   <= r_phase + 2'd1;
            r_residue <= w_residue_nx;
        end
    end

    // Word and line counters advance on each output handshake.
    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            r_x_word <= '0;
            r_y_line <= '0;
        end else if (w_out_hs) begin
            r_x_word <= w_x_inc;
            r_y_line <= w_y_inc;
        end
    end

    stream_out_reg u_out_reg (
        .clk     (out_stream_aclk),
        .rst     (periph_reset),
        .i_load  (w_load),
        .i_data  (w_word),
        .i_user  (w_user),
        .i_last  (w_last),
        .i_ready (bus.out_stream_tready),
        .o_valid (w_out_valid),
        .o_data  (bus.out_stream_tdata),
        .o_user  (bus.out_stream_tuser),
        .o_last  (bus.out_stream_tlast)
    );

    assign bus.in_ready          = w_in_ready;
    assign bus.out_stream_tvalid = w_out_valid;
    assign bus.out_stream_tkeep  = TKEEP_ALL;

endmodule

// File: tb/tb_pixel_packer_24to32.sv
// Scoreboard bench for pixel_packer_24to32 at an 8x2 frame size.
module tb_pixel_packer_24to32;

    localparam int XP = 8;
    localparam int YP = 2;
    localparam int XW = XP * 3 / 4;

    typedef struct packed {
        logic [31:0] d;
        logic        u;
        logic        l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_packer_24to32_if bus();

    pixel_packer_24to32 #(.X_PIXELS(XP), .Y_PIXELS(YP)) dut (
        .out_stream_aclk (clk),
        .periph_reset    (rst),
        .bus             (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int nwords = 0;
    int nuser  = 0;
    int nlast  = 0;
    int mx = 0;
    int my = 0;
    exp_t        q[$];
    logic [23:0] grp[$];

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, expv);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        grp.delete();
        mx = 0;
        my = 0;
    endfunction

    // Reference packing: place the group's pixels in a 96-bit vector and slice
    // word k out once pixel k+1 has arrived.
    function automatic void model_push(logic [23:0] p);
        logic [95:0] v;
        exp_t        e;
        int          n;
        grp.push_back(p);
        n = grp.size();
        if (n >= 2) begin
            v = '0;
            for (int i = 0; i < n; i++) v[24*i +: 24] = grp[i];
            e.d = v[32*(n-2) +: 32];
            e.u = (mx == 0) && (my == 0);
            e.l = (mx == XW - 1);
            q.push_back(e);
            mx++;
            if (mx == XW) begin
                mx = 0;
                my = (my == YP - 1) ? 0 : my + 1;
            end
        end
        if (n == 4) grp.delete();
    endfunction

    // Input side: every accepted pixel feeds the reference model.
    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) model_push(bus.in_pixel);
    end

    // Output side: every word handshake is compared against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_stream_tvalid && bus.out_stream_tready) begin
            nwords++;
            if (bus.out_stream_tuser) nuser++;
            if (bus.out_stream_tlast) nlast++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra got word=%h expected none", bus.out_stream_tdata);
            end else begin
                e = q.pop_front();
                chk("sb_data", bus.out_stream_tdata, e.d);
                chk("sb_user", {31'b0, bus.out_stream_tuser}, {31'b0, e.u});
                chk("sb_last", {31'b0, bus.out_stream_tlast}, {31'b0, e.l});
                chk("sb_keep", {28'b0, bus.out_stream_tkeep}, 32'hF);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        nwords = 0;
        nuser  = 0;
        nlast  = 0;
    endtask

    task automatic send(input logic [23:0] p);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_pixel = p;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 expected 1");
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_stream_tready = 1'b1;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        step();
        chk("sb_drain_left", q.size(), 0);
    endtask

    logic [23:0] pix4 [4];
    logic [31:0] wrd3 [3];
    logic        done;

    initial begin
        pix4[0] = 24'h112233; pix4[1] = 24'h445566;
        pix4[2] = 24'h778899; pix4[3] = 24'hAABBCC;
        wrd3[0] = 32'h66112233; wrd3[1] = 32'h88994455; wrd3[2] = 32'hAABBCC77;

        bus.in_valid = 1'b1;          // ignored while reset is held
        bus.in_pixel = 24'hDEAD00;
        bus.out_stream_tready = 1'b1;
        step();
        do_reset();

        // Reset state
        chk("rst_tvalid", {31'b0, bus.out_stream_tvalid}, 0);
        chk("rst_tuser",  {31'b0, bus.out_stream_tuser}, 0);
        chk("rst_tlast",  {31'b0, bus.out_stream_tlast}, 0);
        chk("rst_tdata",  bus.out_stream_tdata, 0);
        chk("rst_tkeep",  {28'b0, bus.out_stream_tkeep}, 32'hF);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 1);

        // First group: each word visible the cycle after its completing pixel
        send(pix4[0]);
        chk("t1_no_word_p0", {31'b0, bus.out_stream_tvalid}, 0);
        for (int i = 1; i < 4; i++) begin
            send(pix4[i]);
            chk("t1_valid", {31'b0, bus.out_stream_tvalid}, 1);
            chk("t1_data", bus.out_stream_tdata, wrd3[i-1]);
            chk("t1_user", {31'b0, bus.out_stream_tuser}, (i == 1) ? 1 : 0);
        end

        // Rest of the frame plus the first group of the next frame
        for (int i = 4; i < 20; i++) send(24'h100000 * 24'(i) + 24'h00A5C3 + 24'(i));
        drain();
        chk("t2_words", nwords, 15);
        chk("t2_tlast_cnt", nlast, 2);
        chk("t2_tuser_cnt", nuser, 2);

        // Stall with word0 pending: nothing else enters, data holds
        do_reset();
        send(pix4[0]);
        send(pix4[1]);
        bus.out_stream_tready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pixel = pix4[2];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", {31'b0, bus.out_stream_tvalid}, 1);
            chk("t3_hold_data", bus.out_stream_tdata, 32'h66112233);
            chk("t3_in_ready_low", {31'b0, bus.in_ready}, 0);
            step();
        end
        bus.out_stream_tready = 1'b1;
        @(negedge clk);
        chk("t3_release_ready", {31'b0, bus.in_ready}, 1);
        step();
        bus.in_valid = 1'b0;
        send(pix4[3]);
        // Stall with word2 pending: one phase-0 pixel enters, then in_ready drops
        bus.out_stream_tready = 1'b0;
        send(24'hDDEEFF);
        chk("t3_p0_then_block", {31'b0, bus.in_ready}, 0);
        bus.in_valid = 1'b1;
        bus.in_pixel = 24'h010203;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_hold2_data", bus.out_stream_tdata, 32'hAABBCC77);
            chk("t3_hold2_ready", {31'b0, bus.in_ready}, 0);
            step();
        end
        bus.out_stream_tready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        send(24'h040506);
        send(24'h070809);
        drain();
        chk("t3_words", nwords, 6);

        // Random backpressure and random input gaps over three frames
        do_reset();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * XP * YP; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send(24'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    step();
                    bus.out_stream_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        chk("t4_words", nwords, 3 * XW * YP);
        chk("t4_tlast_cnt", nlast, 3 * YP);
        chk("t4_tuser_cnt", nuser, 3);

        // Reset with word1 pending
        do_reset();
        send(pix4[0]);
        send(pix4[1]);
        send(pix4[2]);
        chk("t5_word1_pending", bus.out_stream_tdata, 32'h88994455);
        rst = 1'b1;
        model_reset();
        bus.in_valid = 1'b1;
        bus.in_pixel = 24'hBADBAD;
        step();
        chk("t5_tvalid_cleared", {31'b0, bus.out_stream_tvalid}, 0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        send(pix4[0]);
        send(pix4[1]);
        chk("t5_word0_data", bus.out_stream_tdata, 32'h66112233);
        chk("t5_word0_user", {31'b0, bus.out_stream_tuser}, 1);
        send(pix4[2]);
        send(pix4[3]);
        drain();

        // Continuous traffic: no input stall, output 3 valid then 1 idle
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_pixel = 24'h0F0000 + 24'(i * 24'h010101);
            @(negedge clk);
            chk("t6_in_ready", {31'b0, bus.in_ready}, 1);
            step();
            chk("t6_pattern", {31'b0, bus.out_stream_tvalid}, (i % 4 != 0) ? 1 : 0);
        end
        bus.in_valid = 1'b0;
        drain();
        chk("t6_words", nwords, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
